// File: rtl/capture_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// capture_sequencer_pkg
//   Definitions shared by the acquisition sequencer, the task dispatcher and
//   the transmit readout.
//   - FSM state codes of one acquisition run (IDLE/ARMED/POST/DONE)
//   - trig_match(): trigger comparison used on every sample strobe while armed
// ---------------------------------------------------------------------------
package capture_sequencer_pkg;

  // Sequencer state encoding. The numeric values are fixed because the
  // dispatcher and readout decode them directly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Widest probe sample the trigger helper accepts. Callers zero-extend
  // their samples to this width. Zero bits in the mask never participate,
  // so the extension does not change the result.
  localparam int unsigned CS_MAX_DATA_W = 64;

  // A sample matches when every channel selected by the mask sits at the
  // level given by the value. An all-zero mask matches any sample.
  function automatic logic trig_match(
    input logic [CS_MAX_DATA_W-1:0] i_sample,
    input logic [CS_MAX_DATA_W-1:0] i_value,
    input logic [CS_MAX_DATA_W-1:0] i_mask
  );
    return (((i_sample ^ i_value) & i_mask) == {CS_MAX_DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/capture_sequencer_sample_strobe.sv
// ---------------------------------------------------------------------------
// capture_sequencer_sample_strobe
//   Prescaler for the acquisition clock. It counts 0..i_prescale while it is
//   enabled, and it asserts o_strobe in the cycle where the count equals
//   i_prescale. The count then wraps to 0. A prescale of 0 therefore gives a
//   strobe on every enabled cycle.
// Ports
//   i_clk      in   system clock, rising edge
//   i_rst      in   synchronous active-high reset
//   i_clr      in   synchronous clear of the counter (run start)
//   i_en       in   count enable (sequencer armed or capturing post-trigger)
//   i_prescale in   divider setting, already latched by the caller
//   o_strobe   out  one-cycle sample strobe
// ---------------------------------------------------------------------------
module capture_sequencer_sample_strobe #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_strobe
);

  logic [PRESCALE_W-1:0] r_pcnt;

  // The strobe is decoded from the counter register and is not registered
  // again. The sequencer acts on it in the same cycle, so the first sample
  // is taken exactly prescale+1 cycles after arming.
  assign o_strobe = i_en && (r_pcnt == i_prescale);

  // Prescale counter: clears at run start, wraps after each strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt <= {PRESCALE_W{1'b0}};
    end else if (i_clr) begin
      r_pcnt <= {PRESCALE_W{1'b0}};
    end else if (i_en) begin
      if (o_strobe) begin
        r_pcnt <= {PRESCALE_W{1'b0}};
      end else begin
        r_pcnt <= r_pcnt + PRESCALE_W'(1);
      end
    end else begin
      r_pcnt <= r_pcnt;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// ---------------------------------------------------------------------------
// capture_sequencer
//   Sequences one acquisition run of the logic analyser.
//   - A rising edge of the dispatcher grant starts a run. The configuration
//     is latched on that edge.
//   - On each prescaler strobe, the current probe sample is written into the
//     circular sample memory. The write port is fully registered, so writes
//     appear one cycle after the strobe.
//   - While armed, each strobed sample is tested against the trigger. The
//     trigger sample is written, followed by post_count further samples.
//   - An abort request or loss of the grant ends the run early.
//   - At the end, rd_start_addr/rd_len describe the valid samples
//     oldest-first, and done_acq pulses for one cycle.
// Ports
//   i_clk            in   system clock, rising edge
//   i_rst            in   synchronous active-high reset
//   i_grant_acq      in   acquisition grant (level, rising edge starts run)
//   o_done_acq       out  one-cycle pulse when a run finishes or aborts
//   i_abort          in   host abort request (level)
//   i_prescale       in   sample every prescale+1 clocks (latched at start)
//   i_post_count     in   samples written after the trigger sample (latched)
//   i_trig_mask      in   channels participating in the trigger (latched)
//   i_trig_value     in   required level of participating channels (latched)
//   i_sample_in      in   probe inputs, already synchronised
//   o_mem_we         out  sample memory write enable
//   o_mem_waddr      out  sample memory write address
//   o_mem_wdata      out  sample memory write data
//   o_busy           out  high from start up to and including done_acq
//   o_triggered      out  trigger seen in current/last run
//   o_aborted        out  last run ended by abort or grant loss
//   o_rd_start_addr  out  address of oldest valid sample (valid from done)
//   o_rd_len         out  number of valid samples, 0..DEPTH (valid from done)
// ---------------------------------------------------------------------------
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_grant_acq,
  output logic                  o_done_acq,
  input  logic                  i_abort,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [ADDR_W-1:0]     i_post_count,
  input  logic [DATA_W-1:0]     i_trig_mask,
  input  logic [DATA_W-1:0]     i_trig_value,
  input  logic [DATA_W-1:0]     i_sample_in,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_waddr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_triggered,
  output logic                  o_aborted,
  output logic [ADDR_W-1:0]     o_rd_start_addr,
  output logic [ADDR_W:0]       o_rd_len
);

  // Full memory depth, in the rd_len width so that DEPTH itself fits.
  localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  // ---------------- state and latched configuration ----------------
  logic [1:0]            r_state;
  logic                  r_grant_q;
  logic [PRESCALE_W-1:0] r_prescale_l;
  // post_count is only ADDR_W bits wide, so the latched value never exceeds
  // DEPTH-1 and needs no further clamping.
  logic [ADDR_W-1:0]     r_post_l;
  logic [DATA_W-1:0]     r_mask_l;
  logic [DATA_W-1:0]     r_value_l;
  logic [ADDR_W-1:0]     r_waddr;
  logic                  r_wrapped;
  logic [ADDR_W-1:0]     r_postcnt;

  // ---------------- output registers ----------------
  logic                  r_done_acq;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_waddr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_busy;
  logic                  r_triggered;
  logic                  r_aborted;
  logic [ADDR_W-1:0]     r_rd_start_addr;
  logic [ADDR_W:0]       r_rd_len;

  // ---------------- combinational wires ----------------
  logic                  w_start;
  logic                  w_running;
  logic                  w_stop_req;
  logic                  w_strobe;
  logic                  w_write;
  logic                  w_match;
  logic [ADDR_W-1:0]     w_waddr_nxt;
  logic                  w_wrapped_nxt;
  logic [1:0]            w_state_nxt;
  logic [ADDR_W-1:0]     w_postcnt_nxt;
  logic                  w_trig_set;
  logic                  w_enter_done;

  // A held grant never restarts a run. Only a fresh rising edge seen in IDLE
  // starts one.
  assign w_start    = (r_state == ST_IDLE) && i_grant_acq && !r_grant_q;
  assign w_running  = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_stop_req = w_running && (i_abort || !i_grant_acq);
  // Abort wins over a coincident strobe: that sample is dropped.
  assign w_write    = w_running && w_strobe && !w_stop_req;
  assign w_match    = trig_match(CS_MAX_DATA_W'(i_sample_in),
                                 CS_MAX_DATA_W'(r_value_l),
                                 CS_MAX_DATA_W'(r_mask_l));

  capture_sequencer_sample_strobe #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sample_strobe (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_start),
    .i_en       (w_running),
    .i_prescale (r_prescale_l),
    .o_strobe   (w_strobe)
  );

  // Write pointer after this cycle. It is also the "address after the last
  // write" used when publishing the readout window.
  always_comb begin
    w_waddr_nxt   = r_waddr;
    w_wrapped_nxt = r_wrapped;
    if (w_write) begin
      w_waddr_nxt   = r_waddr + ADDR_W'(1);
      w_wrapped_nxt = r_wrapped || (r_waddr == ADDR_MAX);
    end else begin
      w_waddr_nxt   = r_waddr;
      w_wrapped_nxt = r_wrapped;
    end
  end

  // Run FSM next state, post-trigger countdown and trigger detection.
  always_comb begin
    w_state_nxt   = r_state;
    w_postcnt_nxt = r_postcnt;
    w_trig_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (w_stop_req) begin
          w_state_nxt = ST_DONE;
        end else if (w_write && w_match) begin
          // The trigger sample is written in this cycle. Counting of the
          // post-trigger samples starts with the next strobe.
          w_trig_set    = 1'b1;
          w_postcnt_nxt = r_post_l;
          if (r_post_l == {ADDR_W{1'b0}}) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_POST;
          end
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_POST: begin
        if (w_stop_req) begin
          w_state_nxt = ST_DONE;
        end else if (w_write) begin
          w_postcnt_nxt = r_postcnt - ADDR_W'(1);
          // postcnt is never 0 in POST. Testing <=1 stops a corrupted count
          // from running a full extra lap of the memory.
          if (r_postcnt <= ADDR_W'(1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_POST;
          end
        end else begin
          w_state_nxt = ST_POST;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Only ARMED and POST can move to DONE, so this is the single-cycle entry.
  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  // Sequencer state, latched configuration and write pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_grant_q    <= 1'b0;
      r_prescale_l <= {PRESCALE_W{1'b0}};
      r_post_l     <= {ADDR_W{1'b0}};
      r_mask_l     <= {DATA_W{1'b0}};
      r_value_l    <= {DATA_W{1'b0}};
      r_waddr      <= {ADDR_W{1'b0}};
      r_wrapped    <= 1'b0;
      r_postcnt    <= {ADDR_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_grant_q <= i_grant_acq;
      if (w_start) begin
        r_prescale_l <= i_prescale;
        r_post_l     <= i_post_count;
        r_mask_l     <= i_trig_mask;
        r_value_l    <= i_trig_value;
        r_waddr      <= {ADDR_W{1'b0}};
        r_wrapped    <= 1'b0;
        r_postcnt    <= {ADDR_W{1'b0}};
      end else begin
        r_waddr   <= w_waddr_nxt;
        r_wrapped <= w_wrapped_nxt;
        r_postcnt <= w_postcnt_nxt;
      end
    end
  end

  // Status flags and run completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done_acq  <= 1'b0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done_acq <= w_enter_done;
      if (w_start) begin
        r_busy      <= 1'b1;
        r_triggered <= 1'b0;
        r_aborted   <= 1'b0;
      end else begin
        // busy stays high through the DONE cycle and falls right after it.
        if (r_state == ST_DONE) begin
          r_busy <= 1'b0;
        end
        if (w_trig_set) begin
          r_triggered <= 1'b1;
        end
        if (w_stop_req) begin
          r_aborted <= 1'b1;
        end
      end
    end
  end

  // Registered sample memory write port: one cycle behind the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      r_mem_we <= w_write;
      if (w_write) begin
        r_mem_waddr <= r_waddr;
        r_mem_wdata <= i_sample_in;
      end
    end
  end

  // Readout window, published as the run enters DONE. Once the memory has
  // wrapped, the next slot to write holds the oldest sample and the whole
  // memory is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_start_addr <= {ADDR_W{1'b0}};
      r_rd_len        <= {(ADDR_W+1){1'b0}};
    end else if (w_enter_done) begin
      if (w_wrapped_nxt) begin
        r_rd_start_addr <= w_waddr_nxt;
        r_rd_len        <= DEPTH_LEN;
      end else begin
        r_rd_start_addr <= {ADDR_W{1'b0}};
        r_rd_len        <= {1'b0, w_waddr_nxt};
      end
    end
  end

  assign o_done_acq      = r_done_acq;
  assign o_mem_we        = r_mem_we;
  assign o_mem_waddr     = r_mem_waddr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_busy          = r_busy;
  assign o_triggered     = r_triggered;
  assign o_aborted       = r_aborted;
  assign o_rd_start_addr = r_rd_start_addr;
  assign o_rd_len        = r_rd_len;

endmodule

// File: tb/tb_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_capture_sequencer
//   Self-checking bench for capture_sequencer. It uses a 16-entry memory so
//   that wrap-around is exercised quickly. Each run is planned up front as a
//   list of per-strobe samples. A reference model then walks that list with
//   the trigger/post/abort rules and predicts the writes, the end cycle and
//   the readout window. The bench then drives the DUT cycle by cycle and
//   compares against that prediction.
// ---------------------------------------------------------------------------
module tb_capture_sequencer;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int PRESCALE_W = 8;
  localparam int DEPTH      = 16;
  localparam int MAXS       = 256;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  grant;
  logic                  abort_r;
  logic [PRESCALE_W-1:0] prescale;
  logic [ADDR_W-1:0]     post_count;
  logic [DATA_W-1:0]     mask;
  logic [DATA_W-1:0]     value;
  logic [DATA_W-1:0]     sample;

  logic                  done_acq;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  busy;
  logic                  triggered;
  logic                  aborted;
  logic [ADDR_W-1:0]     rd_start_addr;
  logic [ADDR_W:0]       rd_len;

  int                    n_assert = 0;
  int                    n_fail   = 0;
  string                 cur_run  = "reset";
  logic [DATA_W-1:0]     samp    [MAXS];
  logic [DATA_W-1:0]     cap_mem [DEPTH];

  always #5 clk = ~clk;

  capture_sequencer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_grant_acq     (grant),
    .o_done_acq      (done_acq),
    .i_abort         (abort_r),
    .i_prescale      (prescale),
    .i_post_count    (post_count),
    .i_trig_mask     (mask),
    .i_trig_value    (value),
    .i_sample_in     (sample),
    .o_mem_we        (mem_we),
    .o_mem_waddr     (mem_waddr),
    .o_mem_wdata     (mem_wdata),
    .o_busy          (busy),
    .o_triggered     (triggered),
    .o_aborted       (aborted),
    .o_rd_start_addr (rd_start_addr),
    .o_rd_len        (rd_len)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", cur_run, tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] no_match(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] s;
    s = DATA_W'($urandom);
    if (((s ^ v) & m) == 8'h00) s = s ^ (m & (~m + 8'h01));
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] yes_match(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] v);
    return (DATA_W'($urandom) & ~m) | (v & m);
  endfunction

  // Plan the per-strobe samples: no match before strobe t, a match at t
  // (t < 0: never), random afterwards.
  task automatic fill(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] v, input int t);
    for (int j = 0; j < MAXS; j++) begin
      if (m == 8'h00)  samp[j] = DATA_W'($urandom);
      else if (j < t || t < 0) samp[j] = no_match(m, v);
      else if (j == t) samp[j] = yes_match(m, v);
      else             samp[j] = DATA_W'($urandom);
    end
  endtask

  // One acquisition run. abort_k is the strobe index at which the abort
  // condition is raised (-1: none). hold is the number of extra idle cycles
  // checked after completion while the grant stays where it is.
  task automatic do_run(input string name, input int p, input logic [DATA_W-1:0] m,
                        input logic [DATA_W-1:0] v, input int post, input int abort_k,
                        input bit by_grant, input int hold);
    int n, done_p, rem, jw, exp_len, exp_start;
    bit trig, abrt, ended, we_exp;
    cur_run = name;
    // Reference model: walk the planned strobes.
    n = 0; done_p = 0; rem = 0; trig = 1'b0; abrt = 1'b0; ended = 1'b0;
    for (int j = 0; j < MAXS && !ended; j++) begin
      int sc;
      sc = j * (p + 1) + p;
      if (j == MAXS - 1 && abort_k < 0) abort_k = j;
      if (j == abort_k) begin
        abrt = 1'b1; ended = 1'b1; done_p = sc + 1;
      end else begin
        n++;
        if (!trig) begin
          if (((samp[j] ^ v) & m) == 8'h00) begin
            trig = 1'b1; rem = post;
            if (rem == 0) begin ended = 1'b1; done_p = sc + 1; end
          end
        end else begin
          rem--;
          if (rem == 0) begin ended = 1'b1; done_p = sc + 1; end
        end
      end
    end
    exp_len   = (n >= DEPTH) ? DEPTH : n;
    exp_start = (n >= DEPTH) ? (n % DEPTH) : 0;

    @(negedge clk);
    grant = 1'b0; abort_r = 1'b0; prescale = PRESCALE_W'(p); post_count = ADDR_W'(post);
    mask = m; value = v; sample = DATA_W'($urandom);
    @(negedge clk);
    grant = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= done_p + 1 + hold; c++) begin
      @(negedge clk);
      we_exp = 1'b0; jw = 0;
      if (c >= p + 1 && ((c - 1 - p) % (p + 1)) == 0) begin
        jw = (c - 1 - p) / (p + 1);
        we_exp = (jw < n);
      end
      check("mem_we", 32'(mem_we), 32'(we_exp));
      if (we_exp) begin
        check("mem_waddr", 32'(mem_waddr), 32'(jw % DEPTH));
        check("mem_wdata", 32'(mem_wdata), 32'(samp[jw]));
        cap_mem[jw % DEPTH] = mem_wdata;
      end
      check("done_acq", 32'(done_acq), 32'(c == done_p));
      check("busy", 32'(busy), 32'(c <= done_p));
      if (c == 0) begin
        check("triggered_clr", 32'(triggered), 32'd0);
        check("aborted_clr", 32'(aborted), 32'd0);
      end
      if (c == done_p) begin
        check("triggered", 32'(triggered), 32'(trig));
        check("aborted", 32'(aborted), 32'(abrt));
        check("rd_len", 32'(rd_len), 32'(exp_len));
        check("rd_start_addr", 32'(rd_start_addr), 32'(exp_start));
        if (n >= DEPTH) check("oldest_sample", 32'(cap_mem[exp_start]), 32'(samp[n - DEPTH]));
      end
      // Inputs for period c.
      if (c >= p && ((c - p) % (p + 1)) == 0 && ((c - p) / (p + 1)) < MAXS)
        sample = samp[(c - p) / (p + 1)];
      else
        sample = DATA_W'($urandom);
      if (abort_k >= 0 && c == abort_k * (p + 1) + p) begin
        if (by_grant) grant = 1'b0;
        else          abort_r = 1'b1;
      end else begin
        abort_r = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; grant = 1'b0; abort_r = 1'b0; prescale = '0; post_count = '0;
    mask = '0; value = '0; sample = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(done_acq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_rd_len", 32'(rd_len), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    rst = 1'b0;

    // Free-running trigger, four consecutive writes, then held grant.
    fill(8'h00, 8'h00, 0);
    do_run("t1_basic", 0, 8'h00, 8'hA5, 3, -1, 1'b0, 6);
    // Prescaled sampling, trigger on the fourth strobe.
    fill(8'hFF, 8'h5A, 3);
    do_run("t2_prescale", 2, 8'hFF, 8'h5A, 4, -1, 1'b0, 2);
    // Wrap-around: trigger on strobe 20, 5 post samples -> 26 writes.
    fill(8'h01, 8'h01, 20);
    do_run("t3_wrap", 1, 8'h01, 8'h01, 5, -1, 1'b0, 1);
    // Abort after 7 strobes, by abort request and then by grant loss.
    fill(8'hFF, 8'h3C, -1);
    do_run("t4_abort", 1, 8'hFF, 8'h3C, 9, 7, 1'b0, 2);
    fill(8'hFF, 8'h3C, -1);
    do_run("t4_grant", 0, 8'hFF, 8'h3C, 9, 7, 1'b1, 2);
    // Boundaries: no post samples, abort on the very first strobe, and
    // exactly one full lap of the memory.
    fill(8'h00, 8'h00, 0);
    do_run("post0", 3, 8'h00, 8'h00, 0, -1, 1'b0, 1);
    fill(8'hF0, 8'h90, 2);
    do_run("abort0", 2, 8'hF0, 8'h90, 4, 0, 1'b0, 1);
    fill(8'h80, 8'h80, 0);
    do_run("full_lap", 0, 8'h80, 8'h80, 15, -1, 1'b0, 1);

    // Randomised runs.
    for (int r = 0; r < 10; r++) begin
      int p, t, post, ak;
      logic [DATA_W-1:0] m, v;
      p    = $urandom_range(0, 3);
      m    = ($urandom_range(0, 4) == 0) ? 8'h00 : DATA_W'($urandom);
      v    = DATA_W'($urandom);
      t    = $urandom_range(0, 30);
      post = $urandom_range(0, 15);
      ak   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
      fill(m, v, t);
      do_run($sformatf("rand%0d", r), p, m, v, post, ak, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end

    // Reset in the middle of the post-trigger phase.
    cur_run = "rst_mid_post";
    @(negedge clk);
    grant = 1'b0; abort_r = 1'b0; prescale = 8'd1; post_count = 4'd12; mask = 8'h00;
    @(negedge clk);
    grant = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_triggered", 32'(triggered), 32'd1);
    rst = 1'b1; grant = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done_acq), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_mem_we", 32'(mem_we), 32'd0);
    end

    // The sequencer must still start cleanly after the reset.
    fill(8'h00, 8'h00, 0);
    do_run("after_rst", 0, 8'h00, 8'h00, 2, -1, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
